// File: rtl/mult_seq.sv
// mult_seq: unsigned shift-add multiplier, one partial-product bit per BUSY cycle.
module mult_seq #(
    parameter int Data_width = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      Start,
    input  logic [Data_width-1:0]     A,
    input  logic [Data_width-1:0]     B,
    output logic [2*Data_width-1:0]   P,
    output logic                      Busy,
    output logic                      Done
);
    localparam int CW = $clog2(Data_width + 1);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, next;
    logic [Data_width-1:0] m, q;
    logic [Data_width:0]   acc, sum;
    logic [CW-1:0]         cnt;
    logic                  last;
    always_comb begin
        sum  = acc + (q[0] ? {1'b0, m} : '0);
        last = cnt == CW'(1);
        next = state == IDLE ? (Start ? BUSY : IDLE) :
               state == BUSY ? (last ? DONE : BUSY) : IDLE;
        Busy = state != IDLE;
    end
    always_ff @(posedge CLK or posedge RST)
        if (RST) state <= IDLE;
        else     state <= next;
    // {sum,q} shifted right once: the final shift lands directly in P
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            m    <= '0;
            q    <= '0;
            acc  <= '0;
            cnt  <= '0;
            P    <= '0;
            Done <= 1'b0;
        end else begin
            if (state == IDLE && Start) begin
                m   <= A;
                q   <= B;
                acc <= '0;
                cnt <= CW'(Data_width);
            end else if (state == BUSY) begin
                acc <= {1'b0, sum[Data_width:1]};
                q   <= {sum[0], q[Data_width-1:1]};
                cnt <= cnt - CW'(1);
            end
            Done <= state == BUSY && last;
            if (state == BUSY && last) P <= {sum, q[Data_width-1:1]};
        end
    end
endmodule
